// File: rtl/axi_read_arbiter_if.sv
// Bundle of the requester-side and bus-side read channels of axi_read_arbiter.
//   modport master : the arbiter's view. It receives the CPU requests and the R channel, and it drives AR, RREADY and the per-requester returns.
//   modport slave  : the environment's view (the CPU requesters together with the interconnect).
// Ports carried:
//   req_arvalid/req_arready, req_araddr/req_arlen : two packed CPU read requests (req0 in the low half)
//   req_rvalid/req_rready, req_rdata/rresp/rlast   : routed read beats
//   ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID/ARREADY : shared bus read address
//   RID/RDATA/RRESP/RLAST/RVALID/RREADY           : shared bus read data
//   busy, rid_err                                 : status
interface axi_read_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ID_W   = 4
);
  // CPU side
  logic [1:0]          req_arvalid;
  logic [1:0]          req_arready;
  logic [2*ADDR_W-1:0] req_araddr;
  logic [2*LEN_W-1:0]  req_arlen;
  logic [1:0]          req_rvalid;
  logic [1:0]          req_rready;
  logic [DATA_W-1:0]   req_rdata;
  logic [1:0]          req_rresp;
  logic                req_rlast;

  // Bus side
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  // Status
  logic                busy;
  logic                rid_err;

  modport master (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
    output req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output busy, rid_err
  );

  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_rready,
    input  req_arready, req_rvalid, req_rdata, req_rresp, req_rlast,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  busy, rid_err
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: lets two CPU requesters (req0 = instruction fetch, req1 = data load) share one AXI read channel (AR/R).
// The block grants one burst at a time. It drives the shared AR channel and sends each R beat back to the requester that holds the grant.
// Only one transaction is outstanding at a time, and the grant is held until the RLAST handshake.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : axi_read_arbiter_if.master, which carries the CPU request/return signals, the bus AR/R channels, busy and rid_err
// Configuration:
//   The ARB_RR_EN macro selects how a tie is resolved.
//   - Undefined: fixed priority, and req1 wins any tie.
//   - Defined: round-robin. The requester that was not granted last wins a tie.
module axi_read_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ID_W   = 4
) (
  input logic                clk,
  input logic                reset,
  axi_read_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  localparam logic [2:0] ARSIZE_WORD  = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  state_t            state_q;
  logic              grant_q;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [LEN_W-1:0]  arlen_q;
  logic [ID_W-1:0]   arid_q;
`ifdef ARB_RR_EN
  logic              rr_ptr_q;  // requester favoured on the next tie
`endif

  logic              req_any_c;
  logic              accept_c;
  logic              grant_d;
  logic [ADDR_W-1:0] araddr_d;
  logic [LEN_W-1:0]  arlen_d;
  logic              in_r_c;
  logic              rready_c;
  logic              rid_mismatch_c;
  logic              last_hs_c;
  logic [DATA_W-1:0] rdata_c;
  logic [1:0]        req_rvalid_c;

  // Choose the winner among the live requests and select its address and length.
  always_comb begin : arbitrate
    req_any_c = |bus.req_arvalid;
`ifdef ARB_RR_EN
    // A lone requester wins outright. The pointer decides only a tie.
    if (&bus.req_arvalid) begin
      grant_d = rr_ptr_q;
    end else begin
      grant_d = bus.req_arvalid[1];
    end
`else
    // When req1 asserts, it takes precedence.
    grant_d = bus.req_arvalid[1];
`endif
    accept_c = (state_q == S_IDLE) && req_any_c;
    araddr_d = grant_d ? bus.req_araddr[2*ADDR_W-1:ADDR_W] : bus.req_araddr[ADDR_W-1:0];
    arlen_d  = grant_d ? bus.req_arlen[2*LEN_W-1:LEN_W]    : bus.req_arlen[LEN_W-1:0];
  end

  // Steer the R channel to the granted requester while a burst is in the R phase.
  always_comb begin : r_route
    in_r_c         = (state_q == S_R);
    rready_c       = in_r_c && bus.req_rready[grant_q];
    rid_mismatch_c = in_r_c && bus.RVALID && (bus.RID != arid_q);
    last_hs_c      = in_r_c && bus.RVALID && rready_c && bus.RLAST;
    rdata_c        = bus.RDATA;
    req_rvalid_c   = 2'b00;
    if (in_r_c && bus.RVALID) begin
      req_rvalid_c = grant_q ? 2'b10 : 2'b01;
    end
  end

  // Request acceptance is combinational and is possible only in IDLE.
  assign bus.req_arready = accept_c ? (grant_d ? 2'b10 : 2'b01) : 2'b00;

  assign bus.req_rvalid = req_rvalid_c;
  assign bus.req_rdata  = rdata_c;
  assign bus.req_rlast  = bus.RLAST;
  // A beat whose RID is wrong is still forwarded, but it is reported as SLVERR.
  assign bus.req_rresp  = rid_mismatch_c ? RESP_SLVERR : bus.RRESP;
  assign bus.RREADY     = rready_c;

  assign bus.ARID    = arid_q;
  assign bus.ARADDR  = araddr_q;
  assign bus.ARLEN   = arlen_q;
  assign bus.ARSIZE  = ARSIZE_WORD;
  assign bus.ARBURST = ARBURST_INCR;
  assign bus.ARVALID = arvalid_q;

  assign bus.busy    = (state_q != S_IDLE);
  // rid_err fires once per offending beat, in its handshake cycle.
  assign bus.rid_err = rid_mismatch_c && rready_c;

  // Burst FSM: IDLE -> AR -> R -> IDLE. The AR fields are latched at the grant.
  always_ff @(posedge clk or posedge reset) begin : fsm
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
`ifdef ARB_RR_EN
      rr_ptr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            grant_q   <= grant_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= ID_W'(grant_d);
            arvalid_q <= 1'b1;
            state_q   <= S_AR;
`ifdef ARB_RR_EN
            rr_ptr_q  <= ~grant_d;
`endif
          end
        end
        S_AR: begin
          if (bus.ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_R;
          end
        end
        S_R: begin
          // The state returns to IDLE without granting, so a one-cycle bubble separates bursts.
          if (last_hs_c) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter.
// Expected AR commands and expected R beats go into queues when the stimulus is driven. Each entry is popped and compared when the DUT handshakes it.
module tb_axi_read_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ID_W   = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [ID_W-1:0]   id;
  } ar_exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic              err;
  } beat_exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ar_exp_t   ar_q[$];
  beat_exp_t beat_q[$];

  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) bus ();

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_arvalid = 2'b00;
    bus.req_rready  = 2'b00;
    bus.ARREADY     = 1'b0;
    bus.RVALID      = 1'b0;
    bus.RLAST       = 1'b0;
    bus.RID         = '0;
    bus.RDATA       = '0;
    bus.RRESP       = 2'b00;
  endtask

  // Runs one burst. The caller sets req_araddr/req_arlen. 'win' is the grant the bench expects.
  task automatic run_burst(input logic [1:0] reqs, input bit keep, input logic win,
                           input logic [31:0] addr, input logic [3:0] len, input int ar_delay,
                           input bit toggle, input logic [3:0] rid, input logic [31:0] base);
    ar_exp_t   a;
    beat_exp_t b;
    int        i;
    int        cyc;
    logic      rr;
    // IDLE cycle: this is also the end-of-burst check for any previous burst.
    step();
    bus.RVALID = 1'b0; bus.RLAST = 1'b0; bus.req_rready = 2'b00; bus.ARREADY = 1'b0;
    bus.req_arvalid = reqs;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    total++; if (bus.req_arready !== oh(win)) begin bad++; $display("FAIL grant: req_arready got %b want %b", bus.req_arready, oh(win)); end
    total++; if (bus.rid_err !== 1'b0) begin bad++; $display("FAIL idle_rid_err: got %b want 0", bus.rid_err); end
    a.addr = addr; a.len = len; a.id = 4'(win);
    ar_q.push_back(a);
    // AR phase
    for (int d = 0; d <= ar_delay; d++) begin
      step();
      if (d == 0 && !keep) bus.req_arvalid[win] = 1'b0;
      bus.ARREADY = (d == ar_delay);
      #1;
      total++; if (bus.ARVALID !== 1'b1) begin bad++; $display("FAIL arvalid: cycle %0d got %b want 1", d, bus.ARVALID); end
      total++; if (bus.ARADDR !== ar_q[0].addr) begin bad++; $display("FAIL araddr_stable: cycle %0d got %h want %h", d, bus.ARADDR, ar_q[0].addr); end
      total++; if (bus.req_arready !== 2'b00) begin bad++; $display("FAIL ar_no_grant: got %b want 00", bus.req_arready); end
      if (d == ar_delay) begin
        a = ar_q.pop_front();
        total++; if (bus.ARID !== a.id) begin bad++; $display("FAIL arid: got %h want %h", bus.ARID, a.id); end
        total++; if (bus.ARLEN !== a.len) begin bad++; $display("FAIL arlen: got %h want %h", bus.ARLEN, a.len); end
      end
    end
    // R phase
    i = 0;
    cyc = 0;
    while (i <= int'(len) && cyc < 64) begin
      step();
      bus.ARREADY = 1'b0;
      rr = toggle ? cyc[0] : 1'b1;
      bus.req_rready = rr ? 2'b11 : 2'b00;
      bus.RVALID = 1'b1;
      bus.RDATA  = base + 32'(i);
      bus.RID    = rid;
      bus.RRESP  = 2'(i);
      bus.RLAST  = (i == int'(len));
      if (beat_q.size() == 0) begin
        b.err  = (rid != 4'(win));
        b.data = base + 32'(i);
        b.resp = b.err ? 2'b10 : 2'(i);
        b.last = (i == int'(len));
        beat_q.push_back(b);
      end
      #1;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL r_busy: beat %0d got %b want 1", i, bus.busy); end
      total++; if (bus.req_rvalid !== oh(win)) begin bad++; $display("FAIL req_rvalid: beat %0d got %b want %b", i, bus.req_rvalid, oh(win)); end
      total++; if (bus.RREADY !== rr) begin bad++; $display("FAIL rready: beat %0d got %b want %b", i, bus.RREADY, rr); end
      total++; if (bus.req_arready !== 2'b00 || bus.ARVALID !== 1'b0) begin bad++; $display("FAIL r_quiet_ar: arready %b arvalid %b want 00/0", bus.req_arready, bus.ARVALID); end
      if (rr) begin
        b = beat_q.pop_front();
        total++; if (bus.req_rdata !== b.data) begin bad++; $display("FAIL rdata: beat %0d got %h want %h", i, bus.req_rdata, b.data); end
        total++; if (bus.req_rresp !== b.resp) begin bad++; $display("FAIL rresp: beat %0d got %b want %b", i, bus.req_rresp, b.resp); end
        total++; if (bus.req_rlast !== b.last) begin bad++; $display("FAIL rlast: beat %0d got %b want %b", i, bus.req_rlast, b.last); end
        total++; if (bus.rid_err !== b.err) begin bad++; $display("FAIL rid_err: beat %0d got %b want %b", i, bus.rid_err, b.err); end
        i++;
      end
      cyc++;
    end
    if (i <= int'(len)) begin
      total++; bad++;
      $display("FAIL burst_timeout: beats got %0d want %0d", i, int'(len) + 1);
    end
  endtask

  task automatic go_idle();
    step();
    clear_inputs();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL end_busy: got %b want 0", bus.busy); end
    total++; if (bus.ARVALID !== 1'b0 || bus.RREADY !== 1'b0) begin bad++; $display("FAIL end_quiet: arvalid %b rready %b want 0/0", bus.ARVALID, bus.RREADY); end
    total++; if (bus.rid_err !== 1'b0) begin bad++; $display("FAIL end_rid_err: got %b want 0", bus.rid_err); end
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    ar_q.delete();
    beat_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    bus.req_araddr = '0;
    bus.req_arlen  = '0;
    step();
    bus.RVALID = 1'b1;
    bus.req_rready = 2'b11;
    step();
    total++; if (bus.ARVALID !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", bus.ARVALID); end
    total++; if (bus.ARADDR !== '0 || bus.ARLEN !== '0 || bus.ARID !== '0) begin bad++; $display("FAIL rst_ar_fields: addr %h len %h id %h want 0", bus.ARADDR, bus.ARLEN, bus.ARID); end
    total++; if (bus.RREADY !== 1'b0 || bus.req_rvalid !== 2'b00) begin bad++; $display("FAIL rst_r: rready %b rvalid %b want 0/00", bus.RREADY, bus.req_rvalid); end
    total++; if (bus.busy !== 1'b0 || bus.rid_err !== 1'b0) begin bad++; $display("FAIL rst_status: busy %b rid_err %b want 0/0", bus.busy, bus.rid_err); end
    total++; if (bus.ARSIZE !== 3'b010 || bus.ARBURST !== 2'b01) begin bad++; $display("FAIL rst_consts: size %b burst %b want 010/01", bus.ARSIZE, bus.ARBURST); end
    total++; if (bus.req_arready !== 2'b00) begin bad++; $display("FAIL rst_arready: got %b want 00", bus.req_arready); end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.req_araddr = {32'h0000_0000, 32'h0000_0100};
    bus.req_arlen  = {4'd0, 4'd0};
    run_burst(2'b01, 1'b0, 1'b0, 32'h0000_0100, 4'd0, 0, 1'b0, 4'd0, 32'hDEAD_BEEF);
    go_idle();
  endtask

`ifdef ARB_RR_EN
  task automatic test_round_robin();
    logic w;
    pulse_reset();
    bus.req_araddr = {32'h8000_0000, 32'h0000_0100};
    bus.req_arlen  = {4'd0, 4'd0};
    for (int k = 0; k < 4; k++) begin
      w = (k % 2) == 1;
      run_burst(2'b11, 1'b1, w, w ? 32'h8000_0000 : 32'h0000_0100, 4'd0, 0, 1'b0, 4'(w), 32'h7000_0000 + 32'(k));
    end
    go_idle();
  endtask
`else
  task automatic test_fixed_priority();
    bus.req_araddr = {32'h8000_0000, 32'h0000_0100};
    bus.req_arlen  = {4'd1, 4'd0};
    run_burst(2'b11, 1'b0, 1'b1, 32'h8000_0000, 4'd1, 0, 1'b0, 4'd1, 32'hB000_0000);
    run_burst(2'b01, 1'b0, 1'b0, 32'h0000_0100, 4'd0, 0, 1'b0, 4'd0, 32'hA000_0000);
    // With both requests held, req1 keeps winning.
    run_burst(2'b11, 1'b1, 1'b1, 32'h8000_0000, 4'd1, 1, 1'b0, 4'd1, 32'hB100_0000);
    run_burst(2'b11, 1'b0, 1'b1, 32'h8000_0000, 4'd1, 0, 1'b0, 4'd1, 32'hB200_0000);
    go_idle();
  endtask
`endif

  task automatic test_long_burst();
    bus.req_araddr = {32'h0000_4000, 32'h0000_0000};
    bus.req_arlen  = {4'd3, 4'd0};
    run_burst(2'b10, 1'b0, 1'b1, 32'h0000_4000, 4'd3, 3, 1'b1, 4'd1, 32'hC000_0000);
    go_idle();
  endtask

  task automatic test_rid_mismatch();
    bus.req_araddr = {32'h0000_0000, 32'h0000_0500};
    bus.req_arlen  = {4'd0, 4'd0};
    run_burst(2'b01, 1'b0, 1'b0, 32'h0000_0500, 4'd0, 1, 1'b0, 4'd5, 32'h5555_0000);
    go_idle();
  endtask

  task automatic test_reset_mid_burst();
    bus.req_araddr = {32'h0000_2000, 32'h0000_0000};
    bus.req_arlen  = {4'd3, 4'd0};
    step();
    bus.req_arvalid = 2'b10;
    #1;
    total++; if (bus.req_arready !== 2'b10) begin bad++; $display("FAIL mid_grant: got %b want 10", bus.req_arready); end
    step();
    bus.req_arvalid = 2'b00;
    bus.ARREADY = 1'b1;
    #1;
    total++; if (bus.ARVALID !== 1'b1) begin bad++; $display("FAIL mid_arvalid: got %b want 1", bus.ARVALID); end
    for (int k = 0; k < 3; k++) begin
      step();
      bus.ARREADY = 1'b0;
      bus.RVALID = 1'b1;
      bus.RDATA = 32'h2000_0000 + 32'(k);
      bus.RID = 4'd1;
      bus.RLAST = 1'b0;
      bus.req_rready = 2'b11;
      #1;
      total++; if (bus.req_rvalid !== 2'b10) begin bad++; $display("FAIL mid_rvalid: beat %0d got %b want 10", k, bus.req_rvalid); end
    end
    // Beat 2 is on the bus. Reset must clear the outputs in the same cycle.
    reset = 1'b1;
    #1;
    total++; if (bus.ARVALID !== 1'b0 || bus.RREADY !== 1'b0) begin bad++; $display("FAIL mid_rst_bus: arvalid %b rready %b want 0/0", bus.ARVALID, bus.RREADY); end
    total++; if (bus.req_rvalid !== 2'b00 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_cpu: rvalid %b busy %b want 00/0", bus.req_rvalid, bus.busy); end
    step();
    clear_inputs();
    reset = 1'b0;
    ar_q.delete();
    beat_q.delete();
    bus.req_araddr = {32'h0000_0000, 32'h0000_0300};
    bus.req_arlen  = {4'd0, 4'd1};
    run_burst(2'b01, 1'b0, 1'b0, 32'h0000_0300, 4'd1, 1, 1'b0, 4'd0, 32'h1111_0000);
    go_idle();
  endtask

  initial begin
    reset = 1'b1;
    bus.req_araddr = '0;
    bus.req_arlen  = '0;
    clear_inputs();
    test_reset();
    test_single();
`ifdef ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_long_burst();
    test_rid_mismatch();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
